// File: rtl/run_fifo_manager_p.sv
// run_fifo_manager_p: packs pixel runs and line/frame markers into a token FIFO (optional macro RUN_FIFO_DROP_COUNT_EN).
// Latency: a token written on one edge is visible on dout the next cycle (first-word-fall-through, no bypass).
// Backpressure: runs are dropped when the FIFO cannot accept them; EOL/EOF markers wait in pending flags until accepted.
// Legal configurations satisfy Y_W+1 <= 2*X_W, so a marker's line index fits beside the flag and kind bits.
module run_fifo_manager_p #(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        run_start,
  input  logic [X_W-1:0]        run_end,
  input  logic                  new_run,
  input  logic                  end_line,
  input  logic                  end_frame,
  input  logic                  rd_en,
  output logic [2*X_W:0]        dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           drop_count
);

  localparam int TOK_W = 2*X_W + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [TOK_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic                  eol_q;
  logic                  eof_q;
  logic [Y_W-1:0]        line_idx;
  logic [Y_W-1:0]        eof_idx;

  logic                  eol_req;
  logic                  eof_req;
  logic                  can_wr;
  logic                  wr;
  logic                  rd;
  logic                  wr_eol;
  logic                  wr_eof;
  logic [TOK_W-1:0]      wr_tok;

  // Flags are pure decodes of the occupancy count; the top bit set means exactly DEPTH tokens.
  assign full  = level[DEPTH_LOG2];
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // Select the single token to write this cycle: run first, then EOL, then EOF.
  always_comb begin
    eol_req = eol_q | end_line;
    eof_req = eof_q | end_frame;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    can_wr  = !full | rd_en;
    rd      = rd_en & !empty;
    wr      = 1'b0;
    wr_eol  = 1'b0;
    wr_eof  = 1'b0;
    wr_tok  = '0;
    if (new_run) begin
      wr     = can_wr;
      wr_tok = {1'b0, run_start, run_end};
    end else if (eol_req) begin
      wr               = can_wr;
      wr_eol           = can_wr;
      wr_tok[TOK_W-1]  = 1'b1;
      wr_tok[Y_W:1]    = line_idx;
      wr_tok[0]        = 1'b0;
    end else if (eof_req) begin
      wr               = can_wr;
      wr_eof           = can_wr;
      wr_tok[TOK_W-1]  = 1'b1;
      // A deferred EOF carries the line count seen when the frame ended, not
      // the count after its own line's EOL has since been written.
      wr_tok[Y_W:1]    = eof_q ? eof_idx : line_idx;
      wr_tok[0]        = 1'b1;
    end
  end

  // Pointers, occupancy, pending markers and line numbering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      line_idx <= '0;
      eof_idx  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wr, rd})
        2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
        default: level <= level;
      endcase
      // Repeated requests while a flag is set simply merge into it.
      eol_q <= eol_req & !wr_eol;
      eof_q <= eof_req & !wr_eof;
      if (end_frame && !eof_q) eof_idx <= line_idx;
      if (wr_eof)      line_idx <= '0;
      else if (wr_eol) line_idx <= line_idx + Y_W'(1);
    end
  end

  // Token storage; contents survive reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[wr_ptr] <= wr_tok;
  end

`ifdef RUN_FIFO_DROP_COUNT_EN
  logic [15:0] drop_cnt;

  // Count runs that found no room, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (new_run && !can_wr && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_run_fifo_manager_p.sv
// Directed testbench for run_fifo_manager_p at default parameters.
module tb_run_fifo_manager_p;

  logic        clk;
  logic        rst;
  logic [10:0] run_start;
  logic [10:0] run_end;
  logic        new_run;
  logic        end_line;
  logic        end_frame;
  logic        rd_en;
  logic [22:0] dout;
  logic        empty;
  logic        full;
  logic [6:0]  level;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

`ifdef RUN_FIFO_DROP_COUNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  run_fifo_manager_p dut (
    .clk        (clk),
    .rst        (rst),
    .run_start  (run_start),
    .run_end    (run_end),
    .new_run    (new_run),
    .end_line   (end_line),
    .end_frame  (end_frame),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [22:0] mk_run(input int s, input int e);
    return {1'b0, 11'(s), 11'(e)};
  endfunction

  function automatic logic [22:0] mk_mark(input int idx, input bit kind);
    return {1'b1, 11'd0, 10'(idx), kind};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    run_start = '0;
    run_end   = '0;
    new_run   = 1'b0;
    end_line  = 1'b0;
    end_frame = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_basic();
    do_reset();
    run_start = 11'd5; run_end = 11'd9; new_run = 1'b1; end_line = 1'b1;
    step();
    clear_in();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", empty); end
    checks++; if (dout !== mk_run(5, 9)) begin errors++; $display("FAIL basic_run got=%h exp=%h", dout, mk_run(5, 9)); end
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL basic_level1 got=%0d exp=1", level); end
    step();
    checks++; if (level !== 7'd2) begin errors++; $display("FAIL basic_level2 got=%0d exp=2", level); end
    pop();
    checks++; if (dout !== mk_mark(0, 0)) begin errors++; $display("FAIL basic_eol got=%h exp=%h", dout, mk_mark(0, 0)); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drained got=%b exp=1", empty); end
  endtask

  task automatic test_run_eol_eof();
    logic [22:0] exp [4];
    exp[0] = mk_run(1, 2);
    exp[1] = mk_mark(0, 0);
    exp[2] = mk_mark(0, 1);
    exp[3] = mk_mark(0, 0);
    do_reset();
    run_start = 11'd1; run_end = 11'd2; new_run = 1'b1; end_line = 1'b1; end_frame = 1'b1;
    step();
    clear_in();
    step();
    step();
    end_line = 1'b1;
    step();
    clear_in();
    checks++; if (level !== 7'd4) begin errors++; $display("FAIL trio_level got=%0d exp=4", level); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== exp[i]) begin errors++; $display("FAIL trio_tok%0d got=%h exp=%h", i, dout, exp[i]); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL trio_drained got=%b exp=1", empty); end
  endtask

  task automatic test_line_idx();
    logic [22:0] exp [5];
    exp[0] = mk_mark(0, 0);
    exp[1] = mk_mark(1, 0);
    exp[2] = mk_mark(2, 0);
    exp[3] = mk_mark(3, 1);
    exp[4] = mk_mark(0, 0);
    do_reset();
    end_line = 1'b1;
    step(); step(); step();
    end_line = 1'b0; end_frame = 1'b1;
    step();
    end_frame = 1'b0; end_line = 1'b1;
    step();
    clear_in();
    checks++; if (level !== 7'd5) begin errors++; $display("FAIL idx_level got=%0d exp=5", level); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (dout !== exp[i]) begin errors++; $display("FAIL idx_tok%0d got=%h exp=%h", i, dout, exp[i]); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idx_drained got=%b exp=1", empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      run_start = 11'(i); run_end = 11'(i + 100); new_run = 1'b1;
      step();
    end
    clear_in();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL full_level got=%0d exp=64", level); end
    run_start = 11'd999; run_end = 11'd1000; new_run = 1'b1;
    step();
    clear_in();
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL drop_level got=%0d exp=64", level); end
    checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", drop_count, EXP_DROP); end
    end_line = 1'b1;
    step();
    end_line = 1'b0;
    step();
    step();
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL eol_wait_level got=%0d exp=64", level); end
    pop();
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL eol_pop_level got=%0d exp=64", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL eol_pop_full got=%b exp=1", full); end
    checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL eol_pop_drop got=%0d exp=%0d", drop_count, EXP_DROP); end
    for (int i = 1; i < 64; i++) begin
      checks++; if (dout !== mk_run(i, i + 100)) begin errors++; $display("FAIL drain_run%0d got=%h exp=%h", i, dout, mk_run(i, i + 100)); end
      pop();
    end
    checks++; if (dout !== mk_mark(0, 0)) begin errors++; $display("FAIL drain_eol got=%h exp=%h", dout, mk_mark(0, 0)); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_start = 11'(i); run_end = 11'(i); new_run = 1'b1; end_line = (i == 9);
      step();
    end
    clear_in();
    checks++; if (level !== 7'd10) begin errors++; $display("FAIL mid_level_pre got=%0d exp=10", level); end
    rst = 1'b1; new_run = 1'b1; end_line = 1'b1; end_frame = 1'b1;
    step();
    rst = 1'b0;
    clear_in();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    step(); step(); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_no_marker got=%b exp=1", empty); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL mid_level_post got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_en = 1'b1;
    step();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL b2b_underflow got=%0d exp=0", level); end
    run_start = 11'd7; run_end = 11'd8; new_run = 1'b1;
    step();
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL b2b_level1 got=%0d exp=1", level); end
    checks++; if (dout !== mk_run(7, 8)) begin errors++; $display("FAIL b2b_tok1 got=%h exp=%h", dout, mk_run(7, 8)); end
    run_start = 11'd9; run_end = 11'd10;
    step();
    new_run = 1'b0;
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL b2b_level2 got=%0d exp=1", level); end
    checks++; if (dout !== mk_run(9, 10)) begin errors++; $display("FAIL b2b_tok2 got=%h exp=%h", dout, mk_run(9, 10)); end
    step();
    clear_in();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained got=%b exp=1", empty); end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_basic();
    test_run_eol_eof();
    test_line_idx();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
